// File: rtl/sort_frame_loader.sv
// Serial-to-parallel frame loader feeding the sorting network: a fill buffer collects samples
// while a holding register presents the previous frame, with lane indices tagged alongside.
module sort_frame_loader #(
  parameter int unsigned SIZE                      = 32,
  parameter int unsigned NETWORK_WIDTH             = 8,
  parameter int unsigned INDEX_WIDTH               = 5,
  parameter logic [NETWORK_WIDTH-1:0] PAD_VALUE    = '0,
  parameter int unsigned COUNT_WIDTH               = 16
) (
  input  logic                                     clk,
  input  logic                                     reset_n,
  input  logic [NETWORK_WIDTH-1:0]                 sample_in,
  input  logic                                     sample_valid,
  output logic                                     sample_ready,
  input  logic                                     flush,
  output logic [SIZE-1:0][NETWORK_WIDTH-1:0]       frame_data,
  output logic [SIZE-1:0][INDEX_WIDTH-1:0]         frame_index,
  output logic                                     frame_valid,
  input  logic                                     frame_ready,
  output logic                                     frame_partial,
  output logic [COUNT_WIDTH-1:0]                   frame_count
);

  localparam int unsigned CntW = INDEX_WIDTH + 1;
  localparam logic [CntW-1:0] SizeCnt = CntW'(SIZE);

  logic [SIZE-1:0][NETWORK_WIDTH-1:0] fill_q, fill_d;
  logic [SIZE-1:0][NETWORK_WIDTH-1:0] hold_q, hold_d;
  logic [CntW-1:0]                    fill_cnt_q, fill_cnt_d, cnt_after;
  logic                               flush_pending_q, flush_pending_d;
  logic                               valid_q, valid_d;
  logic                               partial_q, partial_d;
  logic [COUNT_WIDTH-1:0]             count_q, count_d;
  logic                               accept, has_data, hold_free, close, transfer;

  assign sample_ready = reset_n && (fill_cnt_q < SizeCnt) && !flush_pending_q;

  always_comb begin
    accept = sample_valid && sample_ready;
    fill_d = fill_q;
    if (accept) begin
      fill_d[fill_cnt_q[INDEX_WIDTH-1:0]] = sample_in;
    end
    cnt_after = fill_cnt_q + CntW'(accept);
    has_data  = (cnt_after != '0);
    hold_free = !valid_q || frame_ready;
    // A full buffer closes on its own; a flush only closes a non-empty one.
    close     = (cnt_after == SizeCnt) || ((flush || flush_pending_q) && has_data);
    transfer  = close && hold_free;

    hold_d          = hold_q;
    partial_d       = partial_q;
    valid_d         = valid_q && !frame_ready;
    fill_cnt_d      = cnt_after;
    flush_pending_d = flush_pending_q || (flush && has_data);
    count_d         = count_q + COUNT_WIDTH'(valid_q && frame_ready);

    if (transfer) begin
      for (int unsigned k = 0; k < SIZE; k++) begin
        hold_d[k] = (CntW'(k) < cnt_after) ? fill_d[k] : PAD_VALUE;
      end
      partial_d       = (cnt_after != SizeCnt);
      valid_d         = 1'b1;
      fill_cnt_d      = '0;
      flush_pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hold_q          <= '0;
      fill_cnt_q      <= '0;
      flush_pending_q <= 1'b0;
      valid_q         <= 1'b0;
      partial_q       <= 1'b0;
      count_q         <= '0;
    end else begin
      hold_q          <= hold_d;
      fill_cnt_q      <= fill_cnt_d;
      flush_pending_q <= flush_pending_d;
      valid_q         <= valid_d;
      partial_q       <= partial_d;
      count_q         <= count_d;
    end
  end

  // Lanes past fill_cnt are never presented unpadded, so the fill buffer needs no reset.
  always_ff @(posedge clk) begin
    fill_q <= fill_d;
  end

  for (genvar k = 0; k < SIZE; k++) begin : g_idx
    assign frame_index[k] = INDEX_WIDTH'(k);
  end

  assign frame_data    = hold_q;
  assign frame_valid   = valid_q;
  assign frame_partial = partial_q;
  assign frame_count   = count_q;

endmodule

// File: tb/tb_sort_frame_loader.sv
// Directed bench for sort_frame_loader: full, stalled, partial, flush-corner, reset and
// frame-counter wrap scenarios, checked with immediate assertions.
module tb_sort_frame_loader;

  localparam int SIZE = 32;
  localparam int NW   = 8;
  localparam int IW   = 5;
  localparam logic [NW-1:0] PAD = 8'h00;

  logic                      clk = 1'b0;
  logic                      reset_n;
  logic [NW-1:0]             sample_in;
  logic                      sample_valid;
  logic                      sample_ready, sample_ready4;
  logic                      flush;
  logic [SIZE-1:0][NW-1:0]   frame_data, frame_data4;
  logic [SIZE-1:0][IW-1:0]   frame_index, frame_index4;
  logic                      frame_valid, frame_valid4;
  logic                      frame_ready;
  logic                      frame_partial, frame_partial4;
  logic [15:0]               frame_count;
  logic [3:0]                frame_count4;

  int tests = 0;
  int fails = 0;
  int exp_cnt = 0;
  logic [SIZE-1:0][NW-1:0] exp_d;
  logic [SIZE-1:0][IW-1:0] exp_i;

  always #5 clk = ~clk;

  sort_frame_loader u_dut (
    .clk(clk), .reset_n(reset_n), .sample_in(sample_in), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .flush(flush), .frame_data(frame_data),
    .frame_index(frame_index), .frame_valid(frame_valid), .frame_ready(frame_ready),
    .frame_partial(frame_partial), .frame_count(frame_count)
  );

  sort_frame_loader #(.COUNT_WIDTH(4)) u_dut4 (
    .clk(clk), .reset_n(reset_n), .sample_in(sample_in), .sample_valid(sample_valid),
    .sample_ready(sample_ready4), .flush(flush), .frame_data(frame_data4),
    .frame_index(frame_index4), .frame_valid(frame_valid4), .frame_ready(frame_ready),
    .frame_partial(frame_partial4), .frame_count(frame_count4)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Offer one sample and wait (bounded) until it is taken on a clock edge.
  task automatic send(input logic [NW-1:0] v);
    int n;
    sample_in    = v;
    sample_valid = 1'b1;
    n = 0;
    while (!sample_ready && n < 100) begin
      step();
      n++;
    end
    chk("send_ready", sample_ready, 1'b1);
    step();
  endtask

  initial begin
    reset_n = 1'b0; sample_in = '0; sample_valid = 1'b0; flush = 1'b0; frame_ready = 1'b0;
    for (int k = 0; k < SIZE; k++) exp_i[k] = IW'(k);

    // Reset state
    step(); step();
    chk("rst_valid", frame_valid, 1'b0);
    chk("rst_count", frame_count, 16'd0);
    chk("rst_data", frame_data, '0);
    chk("rst_sready", sample_ready, 1'b0);
    chk("rst_index", frame_index, exp_i);
    reset_n = 1'b1;
    step();

    // 1: full frame, sorter always ready
    frame_ready = 1'b1;
    for (int k = 0; k < SIZE; k++) begin
      chk("t1_sready", sample_ready, 1'b1);
      send(NW'(k));
      exp_d[k] = NW'(k);
    end
    sample_valid = 1'b0;
    chk("t1_valid", frame_valid, 1'b1);
    chk("t1_data", frame_data, exp_d);
    chk("t1_index", frame_index, exp_i);
    chk("t1_partial", frame_partial, 1'b0);
    step();
    exp_cnt = 1;
    chk("t1_count", frame_count, 16'(exp_cnt));
    chk("t1_drop", frame_valid, 1'b0);

    // 2: sorter stalled, second frame backs up in the fill buffer
    frame_ready = 1'b0;
    for (int k = 0; k < 2 * SIZE; k++) send(NW'(k));
    sample_in = 8'd64;
    step(); step();
    for (int k = 0; k < SIZE; k++) exp_d[k] = NW'(k);
    chk("t2_stall_sready", sample_ready, 1'b0);
    chk("t2_held_valid", frame_valid, 1'b1);
    chk("t2_held_data", frame_data, exp_d);
    chk("t2_held_count", frame_count, 16'(exp_cnt));
    frame_ready = 1'b1;
    step();
    frame_ready = 1'b0;
    sample_valid = 1'b0;
    exp_cnt++;
    for (int k = 0; k < SIZE; k++) exp_d[k] = NW'(k + SIZE);
    chk("t2_next_data", frame_data, exp_d);
    chk("t2_next_valid", frame_valid, 1'b1);
    chk("t2_next_sready", sample_ready, 1'b1);
    chk("t2_next_count", frame_count, 16'(exp_cnt));
    frame_ready = 1'b1;
    step();
    exp_cnt++;
    chk("t2_drain_valid", frame_valid, 1'b0);

    // 3: partial frame via flush, then a full frame
    frame_ready = 1'b0;
    for (int k = 0; k < 5; k++) send(NW'(10 + k));
    sample_valid = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    for (int k = 0; k < SIZE; k++) exp_d[k] = (k < 5) ? NW'(10 + k) : PAD;
    chk("t3_valid", frame_valid, 1'b1);
    chk("t3_data", frame_data, exp_d);
    chk("t3_partial", frame_partial, 1'b1);
    frame_ready = 1'b1;
    step();
    exp_cnt++;
    for (int k = 0; k < SIZE; k++) begin
      send(NW'(100 + k));
      exp_d[k] = NW'(100 + k);
    end
    sample_valid = 1'b0;
    chk("t3_full_valid", frame_valid, 1'b1);
    chk("t3_full_data", frame_data, exp_d);
    chk("t3_full_partial", frame_partial, 1'b0);
    step();
    exp_cnt++;

    // 4: flush on empty buffer is ignored; flush with last sample gives one full frame
    flush = 1'b1;
    step();
    flush = 1'b0;
    step();
    chk("t4_empty_valid", frame_valid, 1'b0);
    chk("t4_empty_count", frame_count, 16'(exp_cnt));
    for (int k = 0; k < SIZE - 1; k++) send(NW'(50 + k));
    flush = 1'b1;
    send(NW'(50 + SIZE - 1));
    flush = 1'b0;
    sample_valid = 1'b0;
    for (int k = 0; k < SIZE; k++) exp_d[k] = NW'(50 + k);
    chk("t4_last_valid", frame_valid, 1'b1);
    chk("t4_last_partial", frame_partial, 1'b0);
    chk("t4_last_data", frame_data, exp_d);
    step();
    exp_cnt++;
    step(); step();
    chk("t4_no_extra_valid", frame_valid, 1'b0);
    chk("t4_no_extra_count", frame_count, 16'(exp_cnt));

    // 5: reset mid-fill with a frame held
    frame_ready = 1'b0;
    for (int k = 0; k < SIZE + 20; k++) send(NW'(k + 1));
    sample_valid = 1'b0;
    reset_n = 1'b0;
    step();
    chk("t5_rst_valid", frame_valid, 1'b0);
    chk("t5_rst_count", frame_count, 16'd0);
    chk("t5_rst_data", frame_data, '0);
    chk("t5_rst_partial", frame_partial, 1'b0);
    chk("t5_rst_sready", sample_ready, 1'b0);
    reset_n = 1'b1;
    step();
    for (int k = 0; k < SIZE; k++) begin
      send(NW'(200 + k));
      exp_d[k] = NW'(200 + k);
    end
    sample_valid = 1'b0;
    chk("t5_valid", frame_valid, 1'b1);
    chk("t5_data", frame_data, exp_d);
    frame_ready = 1'b1;
    step();
    chk("t5_count", frame_count, 16'd1);

    // 6: 17 frames wrap a 4-bit counter to 1
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    step();
    for (int f = 0; f < 17; f++) begin
      for (int k = 0; k < SIZE; k++) send(NW'(k));
    end
    sample_valid = 1'b0;
    step();
    chk("t6_count4_wrap", frame_count4, 4'd1);
    chk("t6_count16", frame_count, 16'd17);
    chk("t6_valid", frame_valid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
